// File: rtl/sm4_request_arbiter.sv
// Round-robin front end that shares one SM4 encryptor between num_req_p requesters,
// supplies the per-operation LFSR mask and sequences key-cache flushes while idle.
module sm4_request_arbiter #(
    parameter int unsigned num_req_p    = 4,
    parameter int unsigned group_size_p = 128,
    parameter int unsigned word_width_p = 32,
    parameter logic [31:0] lfsr_seed_p  = 32'h1
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p-1:0]              req_v_i,
    output logic [num_req_p-1:0]              req_ready_o,
    input  logic [num_req_p*group_size_p-1:0] req_content_i,
    input  logic [num_req_p*group_size_p-1:0] req_key_i,
    input  logic [num_req_p-1:0]              req_decode_i,
    input  logic [num_req_p-1:0]              req_protect_i,
    output logic [num_req_p-1:0]              resp_v_o,
    output logic [group_size_p-1:0]           resp_crypt_o,
    input  logic [num_req_p-1:0]              resp_yumi_i,
    input  logic                              flush_i,
    output logic                              busy_o,
    output logic [group_size_p-1:0]           enc_content_o,
    output logic [group_size_p-1:0]           enc_key_o,
    output logic [word_width_p-1:0]           enc_random_o,
    output logic                              enc_decode_o,
    output logic                              enc_protect_o,
    output logic                              enc_v_o,
    input  logic                              enc_ready_i,
    input  logic [group_size_p-1:0]           enc_crypt_i,
    input  logic                              enc_v_i,
    output logic                              enc_yumi_o,
    output logic                              enc_invalid_cache_o
);

    localparam int unsigned PtrW     = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam logic [31:0] LfsrTaps = 32'h80200003;

    typedef enum logic [2:0] {eIdle, eIssue, eWait, eReturn, eFlush} state_e;

    state_e                  r_state, w_state_next;
    logic [PtrW-1:0]         r_rr_ptr, r_owner, w_winner, w_scan_idx, w_owner_inc;
    logic                    r_flush_pending;
    logic [31:0]             r_lfsr;
    logic [group_size_p-1:0] r_content, r_key, r_crypt;
    logic                    r_decode, r_protect;
    logic                    w_found, w_grant, w_flush_go, w_lfsr_step, w_capture, w_release;
    int unsigned             w_scan;
    logic [group_size_p-1:0] w_content_a [num_req_p];
    logic [group_size_p-1:0] w_key_a     [num_req_p];

    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign w_content_a[g] = req_content_i[g*group_size_p +: group_size_p];
        assign w_key_a[g]     = req_key_i[g*group_size_p +: group_size_p];
    end

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_scan     = 0;
        w_scan_idx = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            w_scan     = (32'(r_rr_ptr) + i) % num_req_p;
            w_scan_idx = PtrW'(w_scan);
            if (!w_found && req_v_i[w_scan_idx]) begin
                w_found  = 1'b1;
                w_winner = w_scan_idx;
            end
        end
    end

    assign w_owner_inc = (r_owner == PtrW'(num_req_p - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_next        = r_state;
        req_ready_o         = '0;
        resp_v_o            = '0;
        enc_v_o             = 1'b0;
        enc_yumi_o          = 1'b0;
        enc_invalid_cache_o = 1'b0;
        enc_random_o        = '0;
        w_grant             = 1'b0;
        w_flush_go          = 1'b0;
        w_lfsr_step         = 1'b0;
        w_capture           = 1'b0;
        w_release           = 1'b0;
        unique case (r_state)
            eIdle: begin
                if (enc_ready_i) begin
                    if (r_flush_pending) begin
                        w_flush_go   = 1'b1;
                        w_state_next = eFlush;
                    end else if (w_found) begin
                        w_grant               = 1'b1;
                        req_ready_o[w_winner] = 1'b1;
                        w_state_next          = eIssue;
                    end
                end
            end
            eIssue: begin
                enc_v_o      = 1'b1;
                enc_random_o = word_width_p'(r_lfsr);
                if (enc_ready_i) begin
                    w_lfsr_step  = 1'b1;
                    w_state_next = eWait;
                end
            end
            eWait: begin
                enc_yumi_o = enc_v_i;
                if (enc_v_i) begin
                    w_capture    = 1'b1;
                    w_state_next = eReturn;
                end
            end
            eReturn: begin
                resp_v_o[r_owner] = 1'b1;
                if (resp_yumi_i[r_owner]) begin
                    w_release    = 1'b1;
                    w_state_next = eIdle;
                end
            end
            eFlush: begin
                enc_invalid_cache_o = 1'b1;
                w_state_next        = eIdle;
            end
            default: w_state_next = eIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) r_state <= eIdle;
        else            r_state <= w_state_next;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_rr_ptr        <= '0;
            r_owner         <= '0;
            r_flush_pending <= 1'b0;
            r_lfsr          <= lfsr_seed_p;
            r_content       <= '0;
            r_key           <= '0;
            r_decode        <= 1'b0;
            r_protect       <= 1'b0;
            r_crypt         <= '0;
        end else begin
            // A flush arriving on the entry edge merges into the one being serviced.
            if (w_flush_go)   r_flush_pending <= 1'b0;
            else if (flush_i) r_flush_pending <= 1'b1;
            if (w_grant) begin
                r_owner   <= w_winner;
                r_content <= w_content_a[w_winner];
                r_key     <= w_key_a[w_winner];
                r_decode  <= req_decode_i[w_winner];
                r_protect <= req_protect_i[w_winner];
            end
            if (w_lfsr_step) r_lfsr  <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LfsrTaps : '0);
            if (w_capture)   r_crypt <= enc_crypt_i;
            if (w_release)   r_rr_ptr <= w_owner_inc;
        end
    end

    assign busy_o        = (r_state != eIdle);
    assign resp_crypt_o  = r_crypt;
    assign enc_content_o = r_content;
    assign enc_key_o     = r_key;
    assign enc_decode_o  = r_decode;
    assign enc_protect_o = r_protect;

endmodule

// File: tb/tb_sm4_request_arbiter.sv
// Scoreboard bench for sm4_request_arbiter with a small behavioural encryptor stub.
`timescale 1ns/1ps
module tb_sm4_request_arbiter;

    localparam int N = 4;
    localparam int G = 128;
    localparam int W = 32;
    localparam logic [127:0] SM4_VEC = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] SM4_CT  = 128'h681edf34d206965e86b3e94f536e4246;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n_i;
    logic [N-1:0]   req_v_i, req_ready_o, req_decode_i, req_protect_i, resp_v_o, resp_yumi_i;
    logic [N*G-1:0] req_content_i, req_key_i;
    logic [G-1:0]   resp_crypt_o, enc_content_o, enc_key_o, enc_crypt_i;
    logic [W-1:0]   enc_random_o;
    logic           flush_i, busy_o, enc_decode_o, enc_protect_o, enc_v_o;
    logic           enc_ready_i, enc_v_i, enc_yumi_o, enc_invalid_cache_o;

    sm4_request_arbiter #(
        .num_req_p(N), .group_size_p(G), .word_width_p(W), .lfsr_seed_p(32'h1)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o),
        .req_content_i(req_content_i), .req_key_i(req_key_i),
        .req_decode_i(req_decode_i), .req_protect_i(req_protect_i),
        .resp_v_o(resp_v_o), .resp_crypt_o(resp_crypt_o), .resp_yumi_i(resp_yumi_i),
        .flush_i(flush_i), .busy_o(busy_o),
        .enc_content_o(enc_content_o), .enc_key_o(enc_key_o), .enc_random_o(enc_random_o),
        .enc_decode_o(enc_decode_o), .enc_protect_o(enc_protect_o), .enc_v_o(enc_v_o),
        .enc_ready_i(enc_ready_i), .enc_crypt_i(enc_crypt_i), .enc_v_i(enc_v_i),
        .enc_yumi_o(enc_yumi_o), .enc_invalid_cache_o(enc_invalid_cache_o)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int           owner;
        logic [127:0] crypt;
    } exp_t;
    exp_t exp_q[$];

    // Stand-in cipher: the standard vector maps to its published ciphertext, anything else
    // to a cheap operand-dependent scramble so misrouted operands show up.
    function automatic logic [127:0] enc_model(input logic [127:0] c, input logic [127:0] k,
                                               input logic d, input logic p);
        logic [127:0] r;
        if (c == SM4_VEC && k == SM4_VEC && !d && !p) return SM4_CT;
        r = c ^ {k[63:0], k[127:64]};
        if (d) r = ~r;
        if (p) r = {r[126:0], r[127]};
        return r;
    endfunction

    // Encryptor stub: accepts one job, answers after stub_lat cycles, waits for yumi.
    int           stub_lat = 1;
    int           stub_cnt = 0;
    int           stub_jobs = 0;
    logic [127:0] stub_c, stub_k;
    logic         stub_d, stub_p;
    logic [31:0]  issue_rand_q[$];

    initial begin
        enc_ready_i <= 1'b1;
        enc_v_i     <= 1'b0;
        enc_crypt_i <= '0;
        forever begin
            @(posedge clk);
            if (!reset_n_i) begin
                enc_ready_i <= 1'b1;
                enc_v_i     <= 1'b0;
            end else if (enc_v_o && enc_ready_i) begin
                enc_ready_i <= 1'b0;
                stub_cnt    <= stub_lat;
                stub_c      <= enc_content_o;
                stub_k      <= enc_key_o;
                stub_d      <= enc_decode_o;
                stub_p      <= enc_protect_o;
                stub_jobs   <= stub_jobs + 1;
                issue_rand_q.push_back(enc_random_o);
            end else if (!enc_ready_i && !enc_v_i) begin
                if (stub_cnt <= 1) begin
                    enc_v_i     <= 1'b1;
                    enc_crypt_i <= enc_model(stub_c, stub_k, stub_d, stub_p);
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end else if (enc_v_i && enc_yumi_o) begin
                enc_v_i     <= 1'b0;
                enc_ready_i <= 1'b1;
            end
        end
    end

    // Edge monitor: grants, flush pulses and consumed responses, stamped with a cycle count.
    int cyc = 0;
    int grant_q[$];
    int grant_cyc_q[$];
    int multi_hot = 0;
    int inv_count = 0;
    int inv_cyc = 0;
    int consume_cyc = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset_n_i === 1'b1) begin
                if ($countones(req_ready_o) > 1 || $countones(resp_v_o) > 1) multi_hot++;
                for (int k = 0; k < N; k++) begin
                    if (req_ready_o[k]) begin
                        grant_q.push_back(k);
                        grant_cyc_q.push_back(cyc);
                    end
                end
                if (enc_invalid_cache_o) begin
                    inv_count++;
                    inv_cyc = cyc;
                end
                if ((resp_v_o & resp_yumi_i) != '0) consume_cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_op(input int k, input logic [127:0] c, input logic [127:0] key,
                          input logic d, input logic p);
        req_content_i[k*G +: G] = c;
        req_key_i[k*G +: G]     = key;
        req_decode_i[k]         = d;
        req_protect_i[k]        = p;
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        e.owner = k;
        e.crypt = enc_model(req_content_i[k*G +: G], req_key_i[k*G +: G],
                            req_decode_i[k], req_protect_i[k]);
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset_n_i = 1'b0; req_v_i = '0; resp_yumi_i = '0; flush_i = 1'b0;
        repeat (n) @(negedge clk);
        reset_n_i = 1'b1;
    endtask

    task automatic wait_grant(input int n_before, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (grant_q.size() > n_before) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_stub(input int j_before, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (stub_jobs > j_before) begin ok = 1'b1; break; end
        end
    endtask

    task automatic collect_resp(output int who, output logic [N-1:0] rv,
                                output logic [127:0] data, output bit ok);
        ok = 1'b0; who = -1; rv = '0; data = '0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (resp_v_o != '0) begin ok = 1'b1; break; end
        end
        if (ok) begin
            rv   = resp_v_o;
            data = resp_crypt_o;
            for (int k = 0; k < N; k++) if (rv[k]) who = k;
            resp_yumi_i = rv;
            @(negedge clk);
            resp_yumi_i = '0;
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if ({busy_o, req_ready_o, resp_v_o, enc_v_o, enc_yumi_o, enc_invalid_cache_o,
             enc_decode_o, enc_protect_o} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {busy_o, req_ready_o, resp_v_o, enc_v_o,
                     enc_yumi_o, enc_invalid_cache_o, enc_decode_o, enc_protect_o});
        end
        checks++;
        if ({resp_crypt_o, enc_content_o, enc_key_o, enc_random_o} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h/%h exp=0", resp_crypt_o, enc_content_o,
                     enc_key_o, enc_random_o);
        end
    endtask

    task automatic test_single_vector();
        int n0, who; bit ok; logic [N-1:0] rv; logic [127:0] data; exp_t e;
        set_op(1, SM4_VEC, SM4_VEC, 1'b0, 1'b0);
        e.owner = 1; e.crypt = SM4_CT;
        exp_q.push_back(e);
        n0 = grant_q.size();
        req_v_i = 4'b0010;
        wait_grant(n0, ok);
        checks++;
        if (!ok || grant_q[n0] != 1) begin
            failures++;
            $display("FAIL single_grant got=%0d exp=1 (ok=%0d)", ok ? grant_q[n0] : -1, ok);
        end
        checks++;
        if ({enc_v_o, enc_random_o} !== {1'b1, 32'h1}) begin
            failures++;
            $display("FAIL single_issue got v=%b rand=%h exp v=1 rand=00000001", enc_v_o, enc_random_o);
        end
        checks++;
        if ({enc_content_o, enc_key_o} !== {SM4_VEC, SM4_VEC}) begin
            failures++;
            $display("FAIL single_operands got=%h %h exp=%h", enc_content_o, enc_key_o, SM4_VEC);
        end
        req_v_i = '0;
        collect_resp(who, rv, data, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || rv !== 4'b0010 || data !== e.crypt) begin
            failures++;
            $display("FAIL single_resp got v=%b crypt=%h exp v=0010 crypt=%h", rv, data, e.crypt);
        end
        checks++;
        if (resp_crypt_o !== SM4_CT || resp_v_o !== '0) begin
            failures++;
            $display("FAIL single_hold got crypt=%h v=%b exp crypt=%h v=0000", resp_crypt_o, resp_v_o, SM4_CT);
        end
    endtask

    task automatic test_yumi_ignore();
        int n0; bit ok; exp_t e; int bad;
        set_op(1, 128'h00112233_44556677_8899aabb_ccddeeff, 128'hdeadbeef_01020304_a5a5a5a5_0f0f0f0f,
               1'b1, 1'b0);
        push_exp(1);
        n0 = grant_q.size();
        req_v_i = 4'b0010;
        wait_grant(n0, ok);
        req_v_i = '0;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (resp_v_o != '0) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL yumi_resp_timeout got=none exp=resp"); end
        resp_yumi_i = 4'b1000;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_v_o !== 4'b0010) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL yumi_foreign got=%b (bad=%0d) exp=0010", resp_v_o, bad);
        end
        e = exp_q.pop_front();
        checks++;
        if (resp_crypt_o !== e.crypt) begin
            failures++;
            $display("FAIL yumi_crypt got=%h exp=%h", resp_crypt_o, e.crypt);
        end
        resp_yumi_i = 4'b0010;
        @(negedge clk);
        resp_yumi_i = '0;
        checks++;
        if ({resp_v_o, busy_o} !== 5'b0) begin
            failures++;
            $display("FAIL yumi_owner got v=%b busy=%b exp v=0000 busy=0", resp_v_o, busy_o);
        end
    endtask

    task automatic test_round_robin();
        int n0, m0, who; bit ok; logic [N-1:0] rv; logic [127:0] data; exp_t e;
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset(1);
        for (int k = 0; k < N; k++)
            set_op(k, {4{32'hA5000000 + 32'(k)}}, {4{32'h3C3C0000 + 32'(k * 7)}}, k[0], k[1]);
        for (int j = 0; j < 5; j++) push_exp(order[j]);
        n0 = grant_q.size();
        m0 = multi_hot;
        req_v_i = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_grant(n0 + j, ok);
            if (j == 4) req_v_i = '0;
            e = exp_q.pop_front();
            checks++;
            if (!ok || grant_q[n0 + j] != e.owner) begin
                failures++;
                $display("FAIL rr_grant%0d got=%0d exp=%0d", j, ok ? grant_q[n0 + j] : -1, e.owner);
            end
            collect_resp(who, rv, data, ok);
            checks++;
            if (!ok || who != e.owner || data !== e.crypt) begin
                failures++;
                $display("FAIL rr_resp%0d got owner=%0d crypt=%h exp owner=%0d crypt=%h",
                         j, who, data, e.owner, e.crypt);
            end
        end
        checks++;
        if (multi_hot != m0) begin
            failures++;
            $display("FAIL rr_onehot got=%0d multi-bit cycles exp=0", multi_hot - m0);
        end
    endtask

    task automatic test_flush();
        int n0, j0, i0, who; bit ok; logic [N-1:0] rv; logic [127:0] data; exp_t e;
        do_reset(1);
        stub_lat = 4;
        set_op(2, 128'h11111111_22222222_33333333_44444444, 128'h0badf00d_0badf00d_12345678_9abcdef0,
               1'b0, 1'b1);
        set_op(0, 128'hfedcba98_76543210_01234567_89abcdef, 128'h55aa55aa_aa55aa55_00ff00ff_ff00ff00,
               1'b1, 1'b1);
        push_exp(2);
        push_exp(0);
        n0 = grant_q.size();
        j0 = stub_jobs;
        req_v_i = 4'b0100;
        wait_grant(n0, ok);
        req_v_i = '0;
        wait_stub(j0, ok);
        checks++;
        if (!ok || {busy_o, enc_v_o, resp_v_o} !== 6'b100000) begin
            failures++;
            $display("FAIL flush_in_wait got busy=%b v=%b resp=%b exp busy=1 v=0 resp=0000",
                     busy_o, enc_v_o, resp_v_o);
        end
        i0 = inv_count;
        flush_i = 1'b1;
        req_v_i = 4'b0001;
        @(negedge clk);
        flush_i = 1'b0;
        checks++;
        if (enc_invalid_cache_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_during_wait got=%b exp=0", enc_invalid_cache_o);
        end
        collect_resp(who, rv, data, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || who != e.owner || data !== e.crypt) begin
            failures++;
            $display("FAIL flush_resp2 got owner=%0d crypt=%h exp owner=%0d crypt=%h",
                     who, data, e.owner, e.crypt);
        end
        wait_grant(n0 + 1, ok);
        req_v_i = '0;
        checks++;
        if (!ok || inv_count - i0 != 1 || !(inv_cyc > consume_cyc)
            || !(grant_cyc_q[grant_cyc_q.size() - 1] > inv_cyc) || grant_q[grant_q.size() - 1] != 0) begin
            failures++;
            $display("FAIL flush_order got pulses=%0d consume@%0d inv@%0d grant%0d@%0d exp pulses=1 consume<inv<grant0",
                     inv_count - i0, consume_cyc, inv_cyc, grant_q[grant_q.size() - 1],
                     grant_cyc_q[grant_cyc_q.size() - 1]);
        end
        collect_resp(who, rv, data, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || who != e.owner || data !== e.crypt) begin
            failures++;
            $display("FAIL flush_resp0 got owner=%0d crypt=%h exp owner=%0d crypt=%h",
                     who, data, e.owner, e.crypt);
        end
        stub_lat = 1;
    endtask

    task automatic test_lfsr();
        int n0, r0, who; bit ok; logic [N-1:0] rv; logic [127:0] data; exp_t e;
        logic [31:0] exp_rand[3] = '{32'h00000001, 32'h80200003, 32'hC0300002};
        do_reset(1);
        stub_lat = 3;
        r0 = issue_rand_q.size();
        for (int j = 0; j < 3; j++) begin
            set_op(2, {4{32'h0C0FFEE0 + 32'(j)}}, {4{32'h13579BDF ^ 32'(j)}}, 1'b0, j[0]);
            push_exp(2);
            n0 = grant_q.size();
            req_v_i = 4'b0100;
            wait_grant(n0, ok);
            req_v_i = '0;
            collect_resp(who, rv, data, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || who != 2 || data !== e.crypt) begin
                failures++;
                $display("FAIL lfsr_resp%0d got owner=%0d crypt=%h exp owner=2 crypt=%h",
                         j, who, data, e.crypt);
            end
            checks++;
            if (issue_rand_q.size() <= r0 + j || issue_rand_q[r0 + j] !== exp_rand[j]) begin
                failures++;
                $display("FAIL lfsr_rand%0d got=%h exp=%h", j,
                         (issue_rand_q.size() > r0 + j) ? issue_rand_q[r0 + j] : 32'hx, exp_rand[j]);
            end
        end
        stub_lat = 1;
    endtask

    task automatic test_reset_midop();
        int n0, j0, who, stray; bit ok; logic [N-1:0] rv; logic [127:0] data; exp_t e;
        stub_lat = 10;
        set_op(1, 128'h99999999_88888888_77777777_66666666, 128'h1, 1'b0, 1'b0);
        n0 = grant_q.size();
        j0 = stub_jobs;
        req_v_i = 4'b0010;
        wait_grant(n0, ok);
        req_v_i = '0;
        wait_stub(j0, ok);
        reset_n_i = 1'b0;
        @(negedge clk);
        reset_n_i = 1'b1;
        checks++;
        if ({busy_o, resp_v_o, enc_v_o} !== 6'b0 || resp_crypt_o !== '0) begin
            failures++;
            $display("FAIL midop_reset got busy=%b resp=%b v=%b crypt=%h exp all 0",
                     busy_o, resp_v_o, enc_v_o, resp_crypt_o);
        end
        stub_lat = 1;
        stray = 0;
        repeat (15) begin
            @(negedge clk);
            if (resp_v_o != '0 || busy_o) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL midop_abandon got=%0d active cycles exp=0", stray);
        end
        set_op(0, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 128'h2, 1'b1, 1'b0);
        set_op(3, 128'h3, 128'h3, 1'b0, 1'b0);
        push_exp(0);
        n0 = grant_q.size();
        req_v_i = 4'b1001;
        wait_grant(n0, ok);
        req_v_i = '0;
        checks++;
        if (!ok || grant_q[n0] != 0) begin
            failures++;
            $display("FAIL midop_rrptr got=%0d exp=0", ok ? grant_q[n0] : -1);
        end
        collect_resp(who, rv, data, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || who != 0 || data !== e.crypt) begin
            failures++;
            $display("FAIL midop_resp got owner=%0d crypt=%h exp owner=0 crypt=%h", who, data, e.crypt);
        end
    endtask

    initial begin
        reset_n_i = 1'b0; req_v_i = '0; resp_yumi_i = '0; flush_i = 1'b0;
        req_content_i = '0; req_key_i = '0; req_decode_i = '0; req_protect_i = '0;
        test_reset();
        test_single_vector();
        test_yumi_ignore();
        test_round_robin();
        test_flush();
        test_lfsr();
        test_reset_midop();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm4_request_arbiter.md
Name: sm4_request_arbiter

Overview:
- Shares one sm4_encryptor instance between num_req_p requesters.
- Grants requesters round-robin and forwards the winner's operands to the encryptor.
- Supplies the per-operation random mask from an internal 32-bit LFSR.
- Routes the result back to the owning requester and sequences key-cache invalidation so it only occurs while the encryptor is idle.

Parameters:
- num_req_p, 4, number of requesters (2..16).
- group_size_p, 128, block/key width in bits.
- word_width_p, 32, random mask width in bits.
- lfsr_seed_p, 32'h1, LFSR reset value; must be nonzero.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous active-low reset.
- req_v_i  in  num_req_p  per-requester request valid.
- req_ready_o  out  num_req_p  per-requester accept; at most one bit set.
- req_content_i  in  num_req_p*group_size_p  packed plaintext/ciphertext; requester k at bits [k*128 +: 128].
- req_key_i  in  num_req_p*group_size_p  packed keys, same packing.
- req_decode_i  in  num_req_p  1 = decrypt.
- req_protect_i  in  num_req_p  1 = enable masked re-check.
- resp_v_o  out  num_req_p  one-hot result valid.
- resp_crypt_o  out  group_size_p  result, shared by all requesters.
- resp_yumi_i  in  num_req_p  per-requester result consume.
- flush_i  in  1  single-cycle pulse requesting key-cache invalidation.
- busy_o  out  1  high whenever the state is not eIdle.
- enc_content_o  out  group_size_p  to encryptor content_i.
- enc_key_o  out  group_size_p  to encryptor key_i.
- enc_random_o  out  word_width_p  to encryptor random_i.
- enc_decode_o  out  1  to encryptor encode_or_decode_i.
- enc_protect_o  out  1  to encryptor protection_v_i.
- enc_v_o  out  1  to encryptor v_i.
- enc_ready_i  in  1  from encryptor ready_o.
- enc_crypt_i  in  group_size_p  from encryptor crypt_o.
- enc_v_i  in  1  from encryptor v_o.
- enc_yumi_o  out  1  to encryptor yumi_i.
- enc_invalid_cache_o  out  1  to encryptor invalid_cache_i.

Behaviour:
- Reset (reset_n_i=0 at a clock edge) takes priority over everything and sets:
  - state=eIdle, rr_ptr=0, owner=0, flush_pending=0, lfsr=lfsr_seed_p.
  - All operand registers and resp_crypt_o = 0.
  - All outputs = 0.
- Reset mid-operation abandons the in-flight job with no response. The top level drives the encryptor's active-high reset_i from ~reset_n_i.
- flush_pending is set by flush_i in any state. It is cleared only on entry to eFlush. flush_i arriving while flush_pending is already set merges into the single pending flush.
- eIdle:
  - If flush_pending && enc_ready_i: go to eFlush. No grant is given that cycle.
  - Otherwise, if enc_ready_i and any req_v_i is set: the winner is the first set bit scanning from rr_ptr upward, wrapping modulo num_req_p. req_ready_o[winner]=1 combinationally.
  - On the same edge: latch the winner's content, key, decode and protect bits, set owner=winner, go to eIssue.
  - req_ready_o is never asserted outside eIdle.
- eIssue:
  - enc_v_o=1; enc_* outputs drive the latched operands; enc_random_o=lfsr.
  - On enc_v_o && enc_ready_i: advance the LFSR one step and go to eWait.
  - The LFSR is a Galois LFSR, right shift, taps 32'h80200003. It steps only at this handshake.
- eWait:
  - enc_yumi_o = enc_v_i.
  - When enc_v_i=1: capture enc_crypt_i into resp_crypt_o and go to eReturn.
  - No timeout; the arbiter waits indefinitely.
- eReturn:
  - resp_v_o[owner]=1, all other bits 0.
  - On resp_yumi_i[owner]: rr_ptr=(owner+1) mod num_req_p, go to eIdle.
  - resp_yumi_i bits for non-owners are ignored in every state.
- eFlush: enc_invalid_cache_o=1 for exactly one cycle, then go to eIdle.
- Best-case grant-to-issue latency is 1 cycle: grant at edge T, enc_v_o high in cycle T+1.
- One job is outstanding at a time.
- resp_crypt_o holds its value after consumption until the next capture.
- Fairness: a requester that holds req_v_i waits at most num_req_p-1 other jobs before being granted.

Test Plan:
- Single requester 1 with key/content = SM4 standard vector (0123456789abcdeffedcba9876543210), decode=0, protect=0 -> resp_v_o=4'b0010, resp_crypt_o=681edf34d206965e86b3e94f536e4246, enc_random_o=32'h1 at issue.
- All four req_v_i held high from reset, each resp_yumi_i returned immediately -> grant order 0,1,2,3,0; req_ready_o never has more than one bit set.
- flush_i pulsed during eWait of requester 2's job -> response completes first, then enc_invalid_cache_o high for one cycle, then the next grant.
- resp_yumi_i[3] asserted while owner=1 -> ignored; resp_v_o stays 4'b0010 until resp_yumi_i[1].
- Three consecutive jobs -> enc_random_o equals seed, then the 1st and 2nd Galois steps of the seed; the LFSR does not step during eWait/eReturn.
- reset_n_i=0 for one cycle during eWait -> next cycle state=eIdle, busy_o=0, resp_v_o=0, rr_ptr=0, resp_crypt_o=0.
